// File: rtl/inst_cache_pkg.sv
// Shared constants and types for the instruction cache.
//   ICACHE_INDEX_BITS : default line-index width (2**N lines of one word each)
//   ICACHE_IDLE/FETCH : miss state machine encodings
//   mem_rd_t          : read request presented to the memory controller
package inst_cache_pkg;
  localparam int ICACHE_INDEX_BITS = 8;

  localparam logic ICACHE_IDLE  = 1'b0;
  localparam logic ICACHE_FETCH = 1'b1;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } mem_rd_t;
endpackage

// File: rtl/icache_line_array.sv
// Tag/data/valid storage for the direct-mapped instruction cache.
//   clk, rst          : clock, synchronous active-high reset (clears valid bits only)
//   we/widx/wtag/wdata: synchronous line write, sets the line's valid bit
//   ridx              : asynchronous read index
//   rvalid/rtag/rdata : contents of line ridx
module icache_line_array #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic [TAG_BITS-1:0]   wtag,
  input  logic [31:0]           wdata,
  input  logic [INDEX_BITS-1:0] ridx,
  output logic                  rvalid,
  output logic [TAG_BITS-1:0]   rtag,
  output logic [31:0]           rdata
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  always_ff @(posedge clk) begin
    if (rst)     valid       <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller. Hits answer in the same cycle; a miss issues one word
// read, fills the line and forwards the word in the completion cycle.
//   clk, rst             : clock, synchronous active-high reset
//   rdy                  : global enable; low freezes all state
//   jump_wrong           : flush; aborts an outstanding miss
//   fetch_req/fetch_pc   : fetch request (pc[1:0] ignored)
//   fetch_valid/inst     : instruction for fetch_pc this cycle (inst=0 when not valid)
//   mem_req/mem_addr     : word read request to the memory controller
//   mem_done/mem_inst    : read completion and returned word
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_inst
);
  logic        state;
  logic [31:0] miss_addr;

  logic                  line_vld;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic [31:0]           pc_word;
  logic                  in_fetch, hit, fill, bypass;
  mem_rd_t               rd;

  // Masking the byte offset keeps all of fetch_pc in use and gives the
  // word-aligned form directly comparable with miss_addr.
  assign pc_word  = fetch_pc & ~32'h3;
  assign in_fetch = (state == ICACHE_FETCH);
  assign hit      = line_vld && (line_tag == fetch_pc[31:INDEX_BITS+2]);

  // A completion only counts when the block is enabled and not flushed.
  assign fill   = in_fetch && rdy && mem_done && !jump_wrong && !rst;
  assign bypass = fill && fetch_req && (pc_word == miss_addr);

  icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_lines (
    .clk    (clk),
    .rst    (rst),
    .we     (fill),
    .widx   (miss_addr[INDEX_BITS+1:2]),
    .wtag   (miss_addr[31:INDEX_BITS+2]),
    .wdata  (mem_inst),
    .ridx   (fetch_pc[INDEX_BITS+1:2]),
    .rvalid (line_vld),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ICACHE_IDLE;
      miss_addr <= '0;
    end else if (rdy) begin
      if (!in_fetch) begin
        if (fetch_req && !hit && !jump_wrong) begin
          state     <= ICACHE_FETCH;
          miss_addr <= pc_word;
        end
      end else if (jump_wrong || mem_done) begin
        state <= ICACHE_IDLE;
      end
    end
  end

  always_comb begin
    fetch_valid = !rst && !jump_wrong && fetch_req && (hit || bypass);
    fetch_inst  = '0;
    if (fetch_valid) fetch_inst = hit ? line_data : mem_inst;

    // Request drops in the completion/abort cycle so no second read starts.
    rd.req  = !rst && in_fetch && !(rdy && (mem_done || jump_wrong));
    rd.addr = (!rst && in_fetch) ? miss_addr : '0;
  end

  assign mem_req  = rd.req;
  assign mem_addr = rd.addr;
endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, fetch_req, mem_done;
  logic [31:0] fetch_pc, mem_inst;
  logic        fetch_valid, mem_req;
  logic [31:0] fetch_inst, mem_addr;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_inst(mem_inst)
  );

  typedef struct {
    bit        fv;
    bit [31:0] fi;
    bit        mr;
    bit [31:0] ma;
    string     tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: per index, which word address is resident and its word.
  bit        m_valid [256];
  bit [29:0] m_word  [256];
  bit [31:0] m_data  [256];
  bit        m_busy;
  bit [29:0] m_miss;
  string     phase = "reset";

  task automatic step(input bit r, input bit en, input bit jw, input bit req,
                      input bit [31:0] pc, input bit done, input bit [31:0] inst);
    exp_t e;
    bit [29:0] w;
    int i;
    bit h;
    @(negedge clk);
    rst = r; rdy = en; jump_wrong = jw; fetch_req = req;
    fetch_pc = pc; mem_done = done; mem_inst = inst;
    w = pc[31:2];
    i = int'(pc[9:2]);
    h = m_valid[i] && m_word[i] == w;
    e.tag = phase;
    e.fv = 0; e.fi = 0; e.mr = 0; e.ma = 0;
    if (r) begin
      for (int k = 0; k < 256; k++) m_valid[k] = 0;
      m_busy = 0; m_miss = 0;
    end else begin
      e.mr = m_busy && !(en && (done || jw));
      e.ma = m_busy ? {m_miss, 2'b00} : 32'h0;
      if (!jw && req && h) begin
        e.fv = 1; e.fi = m_data[i];
      end else if (!jw && req && m_busy && en && done && w == m_miss) begin
        e.fv = 1; e.fi = inst;
      end
      if (en) begin
        if (jw) m_busy = 0;
        else if (m_busy && done) begin
          m_valid[m_miss[7:0]] = 1;
          m_word[m_miss[7:0]]  = m_miss;
          m_data[m_miss[7:0]]  = inst;
          m_busy = 0;
        end else if (!m_busy && req && !h) begin
          m_busy = 1; m_miss = w;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (fetch_valid !== e.fv || fetch_inst !== e.fi) begin
          failures++;
          $display("FAIL fetch[%s] t=%0t got v=%0b inst=%h want v=%0b inst=%h",
                   e.tag, $time, fetch_valid, fetch_inst, e.fv, e.fi);
        end
        checks++;
        if (mem_req !== e.mr || mem_addr !== e.ma) begin
          failures++;
          $display("FAIL mem[%s] t=%0t got req=%0b addr=%h want req=%0b addr=%h",
                   e.tag, $time, mem_req, mem_addr, e.mr, e.ma);
        end
      end
    end
  end

  initial begin
    bit [31:0] pc;
    rst = 1; rdy = 1; jump_wrong = 0; fetch_req = 0; fetch_pc = 0;
    mem_done = 0; mem_inst = 0;
    m_busy = 0; m_miss = 0;
    for (int k = 0; k < 256; k++) m_valid[k] = 0;

    step(1, 1, 0, 1, 32'h1004, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);

    phase = "cold_miss";
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h1006, 1, 32'h00A00093);

    phase = "refetch";
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 0, 32'h1004, 0, 0);

    phase = "alias";
    step(0, 1, 0, 1, 32'h2004, 0, 0);
    step(0, 1, 0, 1, 32'h2004, 0, 0);
    step(0, 1, 0, 1, 32'h2004, 1, 32'h00000013);
    step(0, 1, 0, 1, 32'h2004, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 1, 32'h00A00093);

    phase = "flush";
    step(0, 1, 0, 1, 32'h3008, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 1, 1, 32'h3008, 1, 32'hDEADBEEF);
    step(0, 1, 0, 0, 32'h3008, 0, 0);
    step(0, 1, 0, 1, 32'h3008, 0, 0);
    step(0, 1, 0, 1, 32'h3008, 0, 0);

    phase = "freeze";
    step(0, 0, 0, 1, 32'h3008, 0, 0);
    step(0, 0, 0, 1, 32'h3008, 1, 32'h11111111);
    step(0, 0, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h3008, 1, 32'h22222222);
    step(0, 1, 0, 1, 32'h3008, 0, 0);

    phase = "reset_mid_fetch";
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h4010, 0, 0);
    step(0, 1, 0, 1, 32'h4010, 0, 0);
    step(1, 1, 0, 1, 32'h4010, 0, 0);
    step(0, 1, 0, 0, 32'h0, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 0, 0);
    step(0, 1, 0, 0, 32'h1004, 0, 0);
    step(0, 1, 0, 1, 32'h1004, 1, 32'h33333333);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 4)
        0: pc = 32'h1004;
        1: pc = 32'h2004;
        2: pc = ($urandom_range(0, 7) << 10) | (($urandom % 8) << 2);
        default: pc = $urandom;
      endcase
      pc = pc | ($urandom % 4);
      step(($urandom % 250) == 0, ($urandom % 8) != 0, ($urandom % 20) == 0,
           ($urandom % 4) != 0, pc, m_busy && (($urandom % 3) == 0), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
